// File: rtl/imem_program_loader.sv
// imem_program_loader
// Boot-time loader that streams a program image into the instruction memory
// and holds the core idle until the image checks out.
//
// Stream format: N[15:8], N[7:0], then 4*N data bytes (big-endian words),
// then one checksum byte equal to the XOR of every header and data byte.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        asynchronous, active-low reset
//   start        single-cycle pulse that begins a load session
//   rx_data      incoming byte
//   rx_valid     rx_data is valid
//   rx_ready     loader can accept a byte (transfer on rx_valid & rx_ready)
//   imem_we      instruction memory write strobe, one cycle per word
//   imem_addr    word address for the write
//   imem_wdata   word to write
//   core_run     high after a load completed with a good checksum
//   busy         high while a session is consuming bytes
//   done         sticky, set on successful load
//   error        sticky, set on oversize count or checksum mismatch
//   words_loaded number of words written in the current session
module imem_program_loader #(
  parameter int LEN_WORD      = 32,
  parameter int LEN_IMEM_ADDR = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     imem_we,
  output logic [LEN_IMEM_ADDR-1:0] imem_addr,
  output logic [LEN_WORD-1:0]      imem_wdata,
  output logic                     core_run,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [LEN_IMEM_ADDR:0]   words_loaded
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // Largest legal word count: the full memory.
  localparam logic [16:0] CAPACITY = 17'd1 << LEN_IMEM_ADDR;

  // Running checksum update for one accepted byte.
  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_e                   state_q, state_d;
  logic [15:0]              n_q, n_d;
  logic [LEN_WORD-1:0]      asm_q, asm_d;
  logic [1:0]               byte_cnt_q, byte_cnt_d;
  logic [LEN_IMEM_ADDR:0]   word_cnt_q, word_cnt_d;
  logic [7:0]               csum_q, csum_d;
  logic                     we_q, we_d;
  logic [LEN_IMEM_ADDR-1:0] addr_q, addr_d;
  logic [LEN_WORD-1:0]      wdata_q, wdata_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     run_q, run_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;

  logic                     accept_s;
  logic [16:0]              hdr_n_s;
  logic [15:0]              next_words_s;
  logic [LEN_WORD-1:0]      shifted_s;

  assign accept_s     = rx_valid && ready_q;
  assign hdr_n_s      = {1'b0, n_q[15:8], rx_data};
  assign next_words_s = 16'(word_cnt_q) + 16'd1;
  assign shifted_s    = {asm_q[LEN_WORD-9:0], rx_data};

  // Next-state and next-output logic for the load sequencer.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    asm_d      = asm_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    error_d    = error_q;
    run_d      = run_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_HDR_HI;
          done_d     = 1'b0;
          error_d    = 1'b0;
          run_d      = 1'b0;
          word_cnt_d = '0;
          csum_d     = 8'd0;
          byte_cnt_d = 2'd0;
          asm_d      = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_HDR_HI: begin
        if (accept_s) begin
          n_d     = {rx_data, 8'd0};
          csum_d  = csum_update(csum_q, rx_data);
          state_d = ST_HDR_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_HDR_LO: begin
        if (accept_s) begin
          n_d    = {n_q[15:8], rx_data};
          csum_d = csum_update(csum_q, rx_data);
          if (hdr_n_s > CAPACITY) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else if (hdr_n_s == 17'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          csum_d = csum_update(csum_q, rx_data);
          asm_d  = shifted_s;
          if (byte_cnt_q == 2'd3) begin
            // Fourth byte completes the word: launch the write next cycle.
            byte_cnt_d = 2'd0;
            we_d       = 1'b1;
            addr_d     = word_cnt_q[LEN_IMEM_ADDR-1:0];
            wdata_d    = shifted_s;
            word_cnt_d = word_cnt_q + 1'b1;
            if (next_words_s == n_q) begin
              state_d = ST_CSUM;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_CSUM: begin
        if (accept_s) begin
          // The checksum byte itself is not folded into the register.
          if (rx_data == csum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            run_d   = 1'b1;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Ready/busy are registered copies of "next state consumes bytes".
    ready_d = (state_d == ST_HDR_HI) || (state_d == ST_HDR_LO) ||
              (state_d == ST_DATA)   || (state_d == ST_CSUM);
    busy_d  = ready_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      n_q        <= 16'd0;
      asm_q      <= '0;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= '0;
      csum_q     <= 8'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      run_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      asm_q      <= asm_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      csum_q     <= csum_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      error_q    <= error_d;
      run_q      <= run_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_ready     = ready_q;
  assign busy         = busy_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign core_run     = run_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = word_cnt_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader: the stimulus side builds each
// image from plain word lists, pushes the expected memory writes into a
// queue, and a monitor pops them whenever imem_we is seen.
module tb_imem_program_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_run;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t  exp_q[$];
  logic prev_we = 1'b0;

  always #5 clk = ~clk;

  imem_program_loader #(.LEN_WORD(32), .LEN_IMEM_ADDR(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_run(core_run),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Monitor: pop one expected write per imem_we cycle.
  always @(negedge clk) begin
    wr_t e;
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write got addr=0x%0h data=0x%0h exp=none", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(imem_addr), 64'(e.addr));
        check("wr_data", 64'(imem_wdata), 64'(e.data));
      end
      check("we_one_cycle", 64'(prev_we), 64'd0);
    end
    if (busy) check("run_low_while_busy", 64'(core_run), 64'd0);
    prev_we <= imem_we;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte; returns one step after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps && $urandom_range(0, 2) == 0) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_ready) begin
      checks++;
      failures++;
      $display("FAIL rx_ready_timeout got=0 exp=1");
    end else begin
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_load(input logic [31:0] words[$], input bit corrupt, input bit gaps,
                          input bit mid_start);
    logic [7:0]  bytes[$];
    logic [7:0]  cs;
    logic [15:0] n16;
    wr_t         w;
    n16 = 16'(words.size());
    bytes.push_back(n16[15:8]);
    bytes.push_back(n16[7:0]);
    foreach (words[i]) begin
      for (int k = 3; k >= 0; k--) bytes.push_back(8'(words[i] >> (8 * k)));
      w.addr = AW'(i);
      w.data = words[i];
      exp_q.push_back(w);
    end
    cs = 8'd0;
    foreach (bytes[i]) cs = cs ^ bytes[i];
    if (corrupt) cs = cs ^ 8'h01;
    bytes.push_back(cs);

    pulse_start();
    check("start_run_cleared", 64'(core_run), 64'd0);
    check("start_busy", 64'(busy), 64'd1);
    check("start_done_cleared", 64'(done), 64'd0);
    check("start_err_cleared", 64'(error), 64'd0);
    check("start_words_cleared", 64'(words_loaded), 64'd0);

    foreach (bytes[i]) begin
      send_byte(bytes[i], gaps);
      if (mid_start && i == 6) begin
        pulse_start();
        check("mid_start_ignored_busy", 64'(busy), 64'd1);
      end
    end
    @(posedge clk); #1;
    check("end_done", 64'(done), 64'(!corrupt));
    check("end_error", 64'(error), 64'(corrupt));
    check("end_core_run", 64'(core_run), 64'(!corrupt));
    check("end_words", 64'(words_loaded), 64'(words.size()));
    check("end_rx_ready", 64'(rx_ready), 64'd0);
    check("end_busy", 64'(busy), 64'd0);
    check("end_writes_seen", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_core_run"}, 64'(core_run), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
    check({tag, "_we"}, 64'(imem_we), 64'd0);
    check({tag, "_addr"}, 64'(imem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] words[$];
    logic [31:0] three[$];

    reset    = 1'b0;
    start    = 1'b0;
    rx_data  = 8'd0;
    rx_valid = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single word, good checksum (0x2C).
    words = {32'h20080005};
    run_load(words, 1'b0, 1'b0, 1'b0);

    // Same image, checksum 0x2D: word still written, load fails.
    run_load(words, 1'b1, 1'b0, 1'b0);

    // Oversize count N=1025: rejected after the second header byte.
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    check("oversize_error", 64'(error), 64'd1);
    check("oversize_ready", 64'(rx_ready), 64'd0);
    check("oversize_busy", 64'(busy), 64'd0);
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("oversize_no_accept", 64'(rx_ready), 64'd0);
    check("oversize_words", 64'(words_loaded), 64'd0);
    check("oversize_done", 64'(done), 64'd0);
    check("oversize_run", 64'(core_run), 64'd0);

    // Empty image.
    words = {};
    run_load(words, 1'b0, 1'b0, 1'b0);

    // Three words with gaps and a mid-load start, then back-to-back.
    three = {32'($urandom), 32'($urandom), 32'($urandom)};
    run_load(three, 1'b0, 1'b1, 1'b1);
    run_load(three, 1'b0, 1'b0, 1'b0);

    // Randomized sessions.
    for (int s = 0; s < 8; s++) begin
      words = {};
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) words.push_back(32'($urandom));
      run_load(words, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0);
    end

    // Capacity boundary: exactly 2**AW words is legal.
    words = {};
    for (int i = 0; i < (1 << AW); i++) words.push_back(32'($urandom));
    run_load(words, 1'b0, 1'b0, 1'b0);

    // Reset during the second word, then reload.
    words = {32'hCAFEF00D, 32'h12345678};
    pulse_start();
    foreach (words[i]) exp_q.push_back('{addr: AW'(i), data: words[i]});
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hCA, 1'b0);
    send_byte(8'hFE, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h0D, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    check("midload_words_before_reset", 64'(words_loaded), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("after_reset_run", 64'(core_run), 64'd0);
    words = {32'h0BADBEEF};
    run_load(words, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Boot-time loader that sits directly upstream of the pipeline's instruction memory and holds the core idle until a program image is in place.
- Accepts a byte stream over valid/ready and assembles big-endian 32-bit words.
- Writes each word into the instruction memory write port, checks a trailing XOR checksum, then releases the core via core_run.

Parameters:
LEN_WORD, 32, instruction word width in bits (fixed at 32; 4 bytes per word)
LEN_IMEM_ADDR, 10, instruction memory word-address width; capacity is 2**LEN_IMEM_ADDR words

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; begins a load session
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data is valid
rx_ready  output  1  loader can accept a byte; transfer occurs when rx_valid and rx_ready are both high
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  LEN_IMEM_ADDR  word address for the write
imem_wdata  output  LEN_WORD  word to write
core_run  output  1  high once a load has completed with a good checksum; drives the core's run/reset release
busy  output  1  high while in HDR_HI, HDR_LO, DATA or CSUM
done  output  1  sticky; set on successful load
error  output  1  sticky; set on oversize count or checksum mismatch
words_loaded  output  LEN_IMEM_ADDR+1  number of words written in the current session

Behaviour:
- Reset (reset low, asynchronous): state IDLE; every output 0; byte counter, word counter, assembly register and checksum register all 0.
- Stream format:
  - 2 header bytes giving word count N, MSB first.
  - Then 4*N data bytes, MSB of each word first (byte 0 -> bits 31:24).
  - Then 1 checksum byte equal to the XOR of both header bytes and all data bytes.
- FSM states: IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR on start:
  - Go to HDR_HI.
  - Clear done, error, core_run, words_loaded and the checksum register; core_run falls on that same edge.
- start in HDR_HI, HDR_LO, DATA or CSUM is ignored.
- rx_ready:
  - Registered; high exactly in HDR_HI, HDR_LO, DATA and CSUM.
  - Low in IDLE, DONE and ERR.
  - Bytes presented while rx_ready is low are not consumed.
- Each accepted byte is XORed into the checksum register, except the checksum byte itself.
- HDR_HI: accept byte -> N[15:8]; go to HDR_LO.
- HDR_LO: accept byte -> N[7:0], then:
  - N > 2**LEN_IMEM_ADDR -> ERR, error=1.
  - N == 0 -> CSUM.
  - Otherwise -> DATA.
- DATA:
  - Shift bytes into the assembly register, counting 0..3.
  - On acceptance of the 4th byte, imem_we is asserted for exactly one cycle on the following cycle, with imem_addr = current word index and imem_wdata = the assembled word.
  - Word index and words_loaded increment with that write.
  - After the N-th word's 4th byte, go to CSUM.
- CSUM: accept byte.
  - Equal to the checksum register -> DONE; done=1 and core_run=1 on the following edge.
  - Not equal -> ERR; error=1; core_run stays 0.
- Stalls: rx_valid low for any number of cycles holds all state; back-to-back bytes are accepted every cycle (full throughput, no bubbles required).
- imem_addr and imem_wdata hold their last values when imem_we is low.
- Words already written before an ERR remain in memory and are not rolled back.
- Reset asserted mid-load aborts immediately: all outputs 0 and core_run held 0 until the next successful load.
- words_loaded saturates naturally at N; the address never wraps because N is bounded by capacity.

Test Plan:
- Single word: start; bytes 0x00 0x01 0x20 0x08 0x00 0x05 0x2C -> one imem_we pulse with addr 0, wdata 0x20080005; then done=1, core_run=1, words_loaded=1, error=0.
- Bad checksum: same stream with last byte 0x2D -> word still written at addr 0; error=1, done=0, core_run=0; rx_ready=0 afterwards.
- Oversize count (LEN_IMEM_ADDR=10): header 0x04 0x01 (N=1025) -> ERR right after the 2nd byte; error=1; no imem_we; following bytes not accepted.
- Empty image: header 0x00 0x00, checksum 0x00 -> done=1, core_run=1, no imem_we, words_loaded=0.
- Backpressure/throughput: 3 words with random rx_valid gaps, then the same 3 words back-to-back -> identical writes at addr 0,1,2, each imem_we pulse one cycle wide; start pulsed mid-load is ignored.
- Reset and reload: assert reset low during the 2nd word -> all outputs 0 asynchronously; release, then start a fresh 1-word load -> completes normally with addr 0, and core_run rises only after the checksum passes.
